mem_access_seq: RTL and testbench
=================================

Name: mem_access_seq

Overview:
Sequences every SLC-3 memory access: takes read/write requests from two requesters (ISDU control FSM = port 0, debug/IO loader = port 1) and arbitrates between them round-robin. It drives the MAR/MDR load enables, the MIO_EN mux select and the active-low SRAM strobes, with a fixed number of wait states. It sits beside the ISDU and replaces the hand-counted memory wait states in the control FSM.

Parameters:
WAIT_CYCLES, 2, number of cycles strobes are held in ACCESS; legal range 1..15
CNT_W, 4, width of wait-state down-counter; must satisfy 2**CNT_W > WAIT_CYCLES

Ports:
Clk  in  1  system clock, all state updates on rising edge
Reset  in  1  synchronous, active-low reset (0 = reset)
Req  in  2  per-requester access request; bit i = requester i
We  in  2  per-requester write flag (1 = write, 0 = read), valid while Req[i]=1
Ack  out  2  one-cycle completion pulse to the granted requester
Grant  out  1  index of the requester owning the current transaction
Busy  out  1  1 whenever state != IDLE
LD_MAR  out  1  load enable for MAR
LD_MDR  out  1  load enable for MDR
MIO_EN  out  1  MDR input select: 1 = memory data, 0 = bus
Mem_CE_n  out  1  SRAM chip enable, active low
Mem_OE_n  out  1  SRAM output enable, active low
Mem_WE_n  out  1  SRAM write enable, active low

Behaviour:
- Moore machine. All outputs are decoded from registered state, grant and transaction-type registers. No combinational path from Req/We to any output.
- States: IDLE, ADDR, ACCESS, FINISH.
- Reset (Reset=0 at a rising edge), from any state including mid-transaction:
  - state <= IDLE, Grant <= 0, rr pointer <= 1 (so requester 0 wins the first tie).
  - Ack = 0, Busy = 0, LD_MAR = 0, LD_MDR = 0, MIO_EN = 0.
  - Mem_CE_n = Mem_OE_n = Mem_WE_n = 1.
  - No Ack is issued for an aborted transaction.
- IDLE: all strobes inactive.
  - If any Req bit = 1, the arbiter picks a winner. Grant <= winner, is_write <= We[winner], state <= ADDR.
  - Tie (Req = 2'b11): grant the requester not granted last. The rr pointer updates on each grant.
- ADDR, one cycle:
  - LD_MAR = 1.
  - For writes: LD_MDR = 1 and MIO_EN = 0 (write data taken from bus).
  - Wait counter <= WAIT_CYCLES-1, then state <= ACCESS.
- ACCESS, WAIT_CYCLES cycles:
  - Mem_CE_n = 0.
  - Reads: Mem_OE_n = 0. Writes: Mem_WE_n = 0.
  - Counter decrements each cycle; at 0, state <= FINISH.
- FINISH, one cycle:
  - Mem_CE_n = 0.
  - Reads: Mem_OE_n = 0, LD_MDR = 1, MIO_EN = 1.
  - Writes: Mem_WE_n = 1 (gives data hold time).
  - Ack[Grant] = 1, then state <= IDLE.
- Latency: Req sampled at edge N puts Ack high during cycle N+WAIT_CYCLES+2. Read data is in MDR from cycle N+WAIT_CYCLES+3.
- Throughput: at least one IDLE cycle between transactions; a new grant can occur in the cycle after FINISH.
- Requester protocol:
  - Hold Req/We stable until Ack.
  - Drop Req in the cycle after Ack, or keep it high to request again. A held Req re-arbitrates in IDLE.
  - Req deasserted mid-transaction is ignored; the transaction completes and Ack still pulses.
  - We changes after grant are ignored (is_write is latched).
- Mem_OE_n and Mem_WE_n are never low in the same cycle. Either strobe low implies Mem_CE_n = 0.

Decomposition:
- mem_seq_pkg: state enum (IDLE, ADDR, ACCESS, FINISH), requester index constants REQ_CPU=0 and REQ_DBG=1, default WAIT_CYCLES.
- One sub-module, rr_arbiter_2: inputs Req[1:0] and a pointer, outputs winner index and valid. Purely combinational; the pointer register lives in mem_access_seq.

Test Plan:
- Reset=0 for 2 cycles with Req=2'b11 -> all strobes 1, Ack=0, Busy=0, LD_* = 0. After Reset=1, first grant goes to requester 0.
- Read, WAIT_CYCLES=2: Req=2'b01, We=0 at edge 0 -> LD_MAR=1 in cycle 1; CE_n=OE_n=0 in cycles 2-4; LD_MDR=MIO_EN=1 and Ack=2'b01 in cycle 4; IDLE in cycle 5.
- Write from requester 1, WAIT_CYCLES=2: Req=2'b10, We=2'b10 -> cycle 1 has LD_MAR=LD_MDR=1, MIO_EN=0; WE_n=0 in cycles 2-3; cycle 4 has WE_n=1, CE_n=0, Ack=2'b10; OE_n stays 1 throughout.
- Contention: Req=2'b11 held for 3 transactions -> Grant sequence 0,1,0; each Ack goes only to the granted bit, with one IDLE cycle between.
- Reset=0 asserted in the 2nd ACCESS cycle -> next cycle IDLE, strobes all 1, no Ack ever pulses for that transaction.
- Req dropped during ACCESS, and WAIT_CYCLES=1 build -> transaction still completes with Ack. For WAIT_CYCLES=1, Ack arrives at cycle N+3.

Source files
------------

// File: rtl/mem_access_seq_pkg.sv
// Shared types and constants for the SLC-3 memory access sequencer.
package mem_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADDR   = 2'd1,
        ACCESS = 2'd2,
        FINISH = 2'd3
    } seq_state_t;

    localparam logic REQ_CPU = 1'b0;   // ISDU control FSM
    localparam logic REQ_DBG = 1'b1;   // debug / IO loader

    localparam int WAIT_CYCLES_DEF = 2;

endpackage

// File: rtl/mem_access_seq_if.sv
// Requester handshake plus datapath/SRAM control lines of the memory sequencer.
interface mem_access_seq_if;

    logic [1:0] Req;
    logic [1:0] We;
    logic [1:0] Ack;
    logic       Grant;
    logic       Busy;
    logic       LD_MAR;
    logic       LD_MDR;
    logic       MIO_EN;
    logic       Mem_CE_n;
    logic       Mem_OE_n;
    logic       Mem_WE_n;

    // Requester / environment side
    modport master (
        output Req, We,
        input  Ack, Grant, Busy, LD_MAR, LD_MDR, MIO_EN,
               Mem_CE_n, Mem_OE_n, Mem_WE_n
    );

    // Sequencer side
    modport slave (
        input  Req, We,
        output Ack, Grant, Busy, LD_MAR, LD_MDR, MIO_EN,
               Mem_CE_n, Mem_OE_n, Mem_WE_n
    );

endinterface

// File: rtl/mem_access_seq_rr_arbiter_2.sv
// Two-way round-robin arbiter; Ptr is the requester granted last and loses ties.
module rr_arbiter_2 (
    input  logic [1:0] Req,
    input  logic       Ptr,
    output logic       Winner,
    output logic       Valid
);

    // Pick the winner; on a tie the requester not granted last wins
    always_comb begin
        Valid = |Req;
        if (Req == 2'b11) begin
            Winner = ~Ptr;
        end else begin
            Winner = Req[1];
        end
    end

endmodule

// File: rtl/mem_access_seq.sv
// SLC-3 memory access sequencer: arbitrates two requesters and drives
// MAR/MDR loads, MIO_EN and the SRAM strobes with a fixed wait-state count.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | no transaction; arbitrate pending requests
//   ADDR   | load MAR (and MDR from bus for writes), arm wait counter
//   ACCESS | SRAM strobes active for WAIT_CYCLES cycles
//   FINISH | capture read data into MDR / release WE_n for hold; Ack
module mem_access_seq
    import mem_seq_pkg::*;
#(
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    mem_access_seq_if.slave  bus
);

    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    seq_state_t       state;
    seq_state_t       state_nxt;
    logic             grant_q;
    logic             is_write;
    logic             rr_ptr;
    logic [CNT_W-1:0] wait_cnt;
    logic             cnt_tc;
    logic             arb_winner;
    logic             arb_valid;
    logic             grant_en;

    rr_arbiter_2 u_arb (
        .Req    (bus.Req),
        .Ptr    (rr_ptr),
        .Winner (arb_winner),
        .Valid  (arb_valid)
    );

    assign grant_en = (state == IDLE) && arb_valid;
    assign cnt_tc   = (wait_cnt == '0);

    // State register
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latch owner, transaction type and round-robin pointer on each grant
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            grant_q  <= REQ_CPU;
            rr_ptr   <= REQ_DBG;
            is_write <= 1'b0;
        end else if (grant_en) begin
            grant_q  <= arb_winner;
            rr_ptr   <= arb_winner;
            is_write <= bus.We[arb_winner];
        end
    end

    // Wait-state down-counter: armed in ADDR, terminal count ends ACCESS
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            wait_cnt <= '0;
        end else if (state == ADDR) begin
            wait_cnt <= WAIT_LOAD;
        end else if ((state == ACCESS) && !cnt_tc) begin
            wait_cnt <= wait_cnt - CNT_W'(1);
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arb_valid) state_nxt = ADDR;
            ADDR:    state_nxt = ACCESS;
            ACCESS:  if (cnt_tc) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Moore output decode from state, owner and transaction type
    always_comb begin
        bus.Ack      = 2'b00;
        bus.Grant    = grant_q;
        bus.Busy     = (state != IDLE);
        bus.LD_MAR   = 1'b0;
        bus.LD_MDR   = 1'b0;
        bus.MIO_EN   = 1'b0;
        bus.Mem_CE_n = 1'b1;
        bus.Mem_OE_n = 1'b1;
        bus.Mem_WE_n = 1'b1;
        case (state)
            ADDR: begin
                bus.LD_MAR = 1'b1;
                bus.LD_MDR = is_write;
            end
            ACCESS: begin
                bus.Mem_CE_n = 1'b0;
                bus.Mem_OE_n = is_write;
                bus.Mem_WE_n = ~is_write;
            end
            FINISH: begin
                // Writes drop WE_n here with CE_n still low for data hold
                bus.Mem_CE_n = 1'b0;
                bus.Mem_OE_n = is_write;
                bus.LD_MDR   = ~is_write;
                bus.MIO_EN   = ~is_write;
                bus.Ack      = (grant_q == REQ_DBG) ? 2'b10 : 2'b01;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_access_seq.sv
// Bench for mem_access_seq: two builds (WAIT_CYCLES=2 and 1) share stimulus;
// each is compared every cycle against a transaction-timeline reference model.
module tb_mem_access_seq;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic [1:0] req = 2'b00;
    logic [1:0] we = 2'b00;

    always #5 Clk = ~Clk;

    mem_access_seq_if ifa ();
    mem_access_seq_if ifb ();

    assign ifa.Req = req;
    assign ifa.We  = we;
    assign ifb.Req = req;
    assign ifb.We  = we;

    mem_access_seq #(.WAIT_CYCLES(2), .CNT_W(4)) dut_a (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (ifa.slave)
    );

    mem_access_seq #(.WAIT_CYCLES(1), .CNT_W(4)) dut_b (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (ifb.slave)
    );

    logic [9:0] obs [2];
    assign obs[0] = {ifa.Ack, ifa.Grant, ifa.Busy, ifa.LD_MAR, ifa.LD_MDR,
                     ifa.MIO_EN, ifa.Mem_CE_n, ifa.Mem_OE_n, ifa.Mem_WE_n};
    assign obs[1] = {ifb.Ack, ifb.Grant, ifb.Busy, ifb.LD_MAR, ifb.LD_MDR,
                     ifb.MIO_EN, ifb.Mem_CE_n, ifb.Mem_OE_n, ifb.Mem_WE_n};

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: a transaction is a timeline of cycles t=1..W+2 after grant
    int wc [2]    = '{2, 1};
    bit m_act [2];
    int m_t [2];
    bit m_g [2];
    bit m_wr [2];
    bit m_ptr [2];
    int ack_cnt [2];
    bit grant_log [$];

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            if (!Reset) begin
                m_act[d] = 1'b0; m_t[d] = 0; m_g[d] = 1'b0; m_ptr[d] = 1'b1;
            end else if (!m_act[d]) begin
                if (req != 2'b00) begin
                    bit w;
                    w = (req == 2'b11) ? ~m_ptr[d] : req[1];
                    m_ptr[d] = w;
                    m_g[d]   = w;
                    m_wr[d]  = we[w];
                    m_act[d] = 1'b1;
                    m_t[d]   = 1;
                end
            end else if (m_t[d] == wc[d] + 2) begin
                m_act[d] = 1'b0;
                m_t[d]   = 0;
            end else begin
                m_t[d]++;
            end
        end
    endtask

    function automatic logic [9:0] exp_vec(input int d);
        logic addr, acc, fin, wr;
        logic [1:0] ack;
        wr   = m_wr[d];
        addr = m_act[d] && (m_t[d] == 1);
        acc  = m_act[d] && (m_t[d] >= 2) && (m_t[d] <= wc[d] + 1);
        fin  = m_act[d] && (m_t[d] == wc[d] + 2);
        ack  = fin ? (m_g[d] ? 2'b10 : 2'b01) : 2'b00;
        return {ack, m_g[d], m_act[d], addr,
                (addr && wr) || (fin && !wr),
                fin && !wr,
                !(acc || fin),
                !((acc || fin) && !wr),
                !(acc && wr)};
    endfunction

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            logic [9:0] e, o;
            string p;
            e = exp_vec(d);
            o = obs[d];
            p = (d == 0) ? "w2" : "w1";
            chk({p, "_ack"},    8'(o[9:8]), 8'(e[9:8]));
            chk({p, "_grant"},  8'(o[7]),   8'(e[7]));
            chk({p, "_busy"},   8'(o[6]),   8'(e[6]));
            chk({p, "_ld_mar"}, 8'(o[5]),   8'(e[5]));
            chk({p, "_ld_mdr"}, 8'(o[4]),   8'(e[4]));
            chk({p, "_mio_en"}, 8'(o[3]),   8'(e[3]));
            chk({p, "_ce_n"},   8'(o[2]),   8'(e[2]));
            chk({p, "_oe_n"},   8'(o[1]),   8'(e[1]));
            chk({p, "_we_n"},   8'(o[0]),   8'(e[0]));
            chk({p, "_oe_we_excl"}, 8'(o[1] | o[0]), 8'd1);
            if (o[9:8] != 2'b00) begin
                ack_cnt[d]++;
                if (d == 0) grant_log.push_back(o[7]);
            end
        end
    endtask

    task automatic step();
        @(posedge Clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (m_act[0] || m_act[1]); i++) step();
        chk("drain_timeout", 8'(m_act[0] || m_act[1]), 8'd0);
    endtask

    initial begin
        int acks_before;

        // Reset with both requesting
        Reset = 1'b0; req = 2'b11; we = 2'b00;
        step();
        step();

        // Contention: held tie alternates owners starting with requester 0
        Reset = 1'b1;
        grant_log.delete();
        for (int i = 0; i < 40 && grant_log.size() < 3; i++) step();
        chk("contention_count", 8'(grant_log.size()), 8'd3);
        if (grant_log.size() >= 3) begin
            chk("contention_g0", 8'(grant_log[0]), 8'd0);
            chk("contention_g1", 8'(grant_log[1]), 8'd1);
            chk("contention_g2", 8'(grant_log[2]), 8'd0);
        end
        req = 2'b00;
        drain();

        // Read from requester 0, Req dropped after grant
        req = 2'b01; we = 2'b00;
        step();
        req = 2'b00;
        for (int i = 0; i < 6; i++) step();

        // Write from requester 1, Req dropped mid-ACCESS, We flipped after grant
        req = 2'b10; we = 2'b10;
        step();
        we = 2'b00;
        step();
        step();
        req = 2'b00;
        for (int i = 0; i < 5; i++) step();

        // Reset during second ACCESS cycle aborts without Ack
        req = 2'b01; we = 2'b00;
        step();
        step();
        step();
        acks_before = ack_cnt[0];
        Reset = 1'b0; req = 2'b00;
        step();
        Reset = 1'b1;
        for (int i = 0; i < 6; i++) step();
        chk("abort_no_ack", 8'(ack_cnt[0]), 8'(acks_before));

        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                req = 2'($urandom_range(0, 3));
                we  = 2'($urandom_range(0, 3));
            end
            Reset = ($urandom_range(0, 49) != 0);
            step();
        end
        Reset = 1'b1; req = 2'b00;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
